fetch_stall_ctrl: RTL and testbench

//  Consumer end of the load-use hazard interface: owns the PC and the IF/ID pipeline register.

---
 rtl/fetch_stall_ctrl_if.sv | 41 ++++
 rtl/fetch_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stall_ctrl_if.sv
// Fetch/hazard bundle between the hazard unit, instruction memory, decode and fetch_stall_ctrl.
// STALL_STATS_EN adds the stall_cycles / flush_count statistics signals.
interface fetch_stall_ctrl_if;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_mux_select;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        id_ex_bubble;
    logic        stall_active;
    logic        ctrl_error;
    logic        stall_timeout;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    // Environment side: hazard unit, EX redirect and instruction memory.
    modport master (
        output pc_write, if_id_write, id_ex_mux_select, branch_taken, branch_target, imem_instr,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, id_ex_bubble, stall_active,
               ctrl_error, stall_timeout
`ifdef STALL_STATS_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  pc_write, if_id_write, id_ex_mux_select, branch_taken, branch_target, imem_instr,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, id_ex_bubble, stall_active,
               ctrl_error, stall_timeout
`ifdef STALL_STATS_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// PC and IF/ID owner applying load-use stalls and branch flushes, with hazard-control checking.
// Optional STALL_STATS_EN macro adds stall_cycles and flush_count statistics counters.
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned MAX_STALL = 8
) (
    input logic              clk,
    input logic              rst,
    fetch_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_AT = 9'(MAX_STALL + 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  stall_cnt;
    logic [7:0]  stall_cnt_next;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        ctrl_error;
    logic        stall_timeout;
    logic        both_low;
    logic        both_high;
    logic        error_hit;
    logic        timeout_hit;

    assign both_low  = ~bus.pc_write & ~bus.if_id_write;
    assign both_high =  bus.pc_write &  bus.if_id_write;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        if (bus.branch_taken) begin
            state_next     = ST_FLUSH;
            stall_cnt_next = 8'd0;
        end else begin
            unique case (state)
                ST_RUN, ST_FLUSH: begin
                    if (both_low) begin
                        state_next     = ST_STALL;
                        stall_cnt_next = 8'd1;
                    end else begin
                        state_next     = ST_RUN;
                        stall_cnt_next = 8'd0;
                    end
                end
                ST_STALL: begin
                    if (both_high) begin
                        state_next     = ST_RUN;
                        stall_cnt_next = 8'd0;
                    end else if (stall_cnt != 8'hFF) begin
                        stall_cnt_next = stall_cnt + 8'd1;
                    end
                end
                default: begin
                    state_next     = ST_RUN;
                    stall_cnt_next = 8'd0;
                end
            endcase
        end
    end

    // A FLUSH cycle and a redirect edge legitimately disagree on the two write enables.
    assign error_hit   = (state != ST_FLUSH) & ~bus.branch_taken & (bus.pc_write ^ bus.if_id_write);
    assign timeout_hit = {1'b0, stall_cnt_next} >= TIMEOUT_AT;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RUN;
            stall_cnt     <= 8'd0;
            ctrl_error    <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            state         <= state_next;
            stall_cnt     <= stall_cnt_next;
            ctrl_error    <= ctrl_error | error_hit;
            stall_timeout <= stall_timeout | timeout_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.branch_taken) begin
            pc <= bus.branch_target;
        end else if (bus.pc_write) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (bus.branch_taken) begin
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (bus.if_id_write) begin
            if_id_pc    <= pc;
            if_id_instr <= bus.imem_instr;
            if_id_valid <= 1'b1;
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (state == ST_STALL) stall_cycles <= stall_cycles + 32'd1;
            if (bus.branch_taken)  flush_count  <= flush_count + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles;
    assign bus.flush_count  = flush_count;
`endif

    assign bus.imem_addr     = pc;
    assign bus.if_id_pc      = if_id_pc;
    assign bus.if_id_instr   = if_id_instr;
    assign bus.if_id_valid   = if_id_valid;
    assign bus.stall_active  = (state == ST_STALL);
    assign bus.ctrl_error    = ctrl_error;
    assign bus.stall_timeout = stall_timeout;
    // The empty IF/ID after reset would request a bubble; it is held low while rst is asserted.
    assign bus.id_ex_bubble  = ~rst & (bus.id_ex_mux_select | (state == ST_FLUSH) | ~if_id_valid);

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: a cycle-level reference model compared every negedge,
// plus literal checkpoints for the documented scenarios.
module tb_fetch_stall_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] INSTR = 32'h00A0_0093;
    localparam int          MAXS  = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fetch_stall_ctrl_if bus ();

    fetch_stall_ctrl #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP),
        .MAX_STALL(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pipeline contents plus the length of the current stall run.
    logic [31:0] m_pc, m_ifpc, m_instr, m_sc, m_fc;
    logic        m_valid, m_flush, m_err, m_to;
    int          m_len;

    function automatic int next_len(input int len, input logic bt, input logic pw, input logic iw);
        if (bt) return 0;
        if (len == 0) return (!pw && !iw) ? 1 : 0;
        if (pw && iw) return 0;
        return (len < 255) ? len + 1 : 255;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 32'd0; m_ifpc <= 32'd0; m_instr <= NOP; m_valid <= 1'b0;
            m_flush <= 1'b0; m_err <= 1'b0; m_to <= 1'b0; m_len <= 0;
            m_sc <= 32'd0; m_fc <= 32'd0;
        end else begin
            m_pc <= bus.branch_taken ? bus.branch_target : (bus.pc_write ? m_pc + 32'd4 : m_pc);
            if (bus.branch_taken) begin
                m_ifpc <= 32'd0; m_instr <= NOP; m_valid <= 1'b0;
            end else if (bus.if_id_write) begin
                m_ifpc <= m_pc; m_instr <= bus.imem_instr; m_valid <= 1'b1;
            end
            if (!m_flush && !bus.branch_taken && (bus.pc_write != bus.if_id_write)) m_err <= 1'b1;
            if (next_len(m_len, bus.branch_taken, bus.pc_write, bus.if_id_write) > MAXS) m_to <= 1'b1;
            m_len   <= next_len(m_len, bus.branch_taken, bus.pc_write, bus.if_id_write);
            m_flush <= bus.branch_taken;
            if (m_len > 0)        m_sc <= m_sc + 32'd1;
            if (bus.branch_taken) m_fc <= m_fc + 32'd1;
        end
    end

    always @(negedge clk) begin
        check("imem_addr",     bus.imem_addr,   m_pc);
        check("if_id_pc",      bus.if_id_pc,    m_ifpc);
        check("if_id_instr",   bus.if_id_instr, m_instr);
        check("if_id_valid",   32'(bus.if_id_valid),   32'(m_valid));
        check("id_ex_bubble",  32'(bus.id_ex_bubble),
              32'(!rst && (bus.id_ex_mux_select || m_flush || !m_valid)));
        check("stall_active",  32'(bus.stall_active),  32'(m_len > 0));
        check("ctrl_error",    32'(bus.ctrl_error),    32'(m_err));
        check("stall_timeout", 32'(bus.stall_timeout), 32'(m_to));
`ifdef STALL_STATS_EN
        check("stall_cycles",  bus.stall_cycles, m_sc);
        check("flush_count",   bus.flush_count,  m_fc);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic pw, input logic iw, input logic mux, input logic bt,
                         input logic [31:0] tgt);
        bus.pc_write         = pw;
        bus.if_id_write      = iw;
        bus.id_ex_mux_select = mux;
        bus.branch_taken     = bt;
        bus.branch_target    = tgt;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #3 rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.imem_instr = INSTR;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        #12;
        check("rst imem_addr",    bus.imem_addr,   32'h0);
        check("rst if_id_instr",  bus.if_id_instr, NOP);
        check("rst if_id_valid",  32'(bus.if_id_valid),  32'd0);
        check("rst id_ex_bubble", 32'(bus.id_ex_bubble), 32'd0);
        rst = 1'b0;

        // Free-running fetch.
        cyc(4);
        check("t1 imem_addr",    bus.imem_addr,  32'h10);
        check("t1 if_id_pc",     bus.if_id_pc,   32'hC);
        check("t1 if_id_valid",  32'(bus.if_id_valid),  32'd1);
        check("t1 id_ex_bubble", 32'(bus.id_ex_bubble), 32'd0);
        check("t1 stall_active", 32'(bus.stall_active), 32'd0);

        // Load-use stall at PC 0x8.
        pulse_reset();
        cyc(2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        #1 check("t2 bubble comb", 32'(bus.id_ex_bubble), 32'd1);
        cyc(1);
        check("t2 pc held",      bus.imem_addr, 32'h8);
        check("t2 if_id held",   bus.if_id_pc,  32'h4);
        check("t2 stall_active", 32'(bus.stall_active), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1);
        check("t2 resume pc",    bus.imem_addr, 32'hC);
        check("t2 ctrl_error",   32'(bus.ctrl_error), 32'd0);

        // Branch beats a simultaneous stall; mismatched enables during FLUSH are tolerated.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        cyc(1);
        check("t3 imem_addr",    bus.imem_addr,   32'h100);
        check("t3 if_id_instr",  bus.if_id_instr, NOP);
        check("t3 if_id_valid",  32'(bus.if_id_valid),  32'd0);
        check("t3 flush bubble", 32'(bus.id_ex_bubble), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1);
        check("t3 no err in flush", 32'(bus.ctrl_error),   32'd0);
        check("t3 back to run",     32'(bus.stall_active), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        cyc(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1);
        check("t3 flush to stall", 32'(bus.stall_active), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1);

        // Stall of MAX_STALL+1 cycles raises the sticky timeout.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(MAXS);
        check("t4 no timeout yet", 32'(bus.stall_timeout), 32'd0);
        cyc(1);
        check("t4 timeout",        32'(bus.stall_timeout), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(2);
        check("t4 timeout sticky", 32'(bus.stall_timeout), 32'd1);

        // Inconsistent enables, then reset in the middle of a stall.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1);
        check("t5 ctrl_error", 32'(bus.ctrl_error), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(2);
        check("t5 sticky err", 32'(bus.ctrl_error), 32'd1);
        #2 rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        #1;
        check("t5 rst pc",      bus.imem_addr, 32'h0);
        check("t5 rst err",     32'(bus.ctrl_error),    32'd0);
        check("t5 rst timeout", 32'(bus.stall_timeout), 32'd0);
        check("t5 rst stall",   32'(bus.stall_active),  32'd0);
        #1 rst = 1'b0;

        // Statistics and PC wrap.
        pulse_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        cyc(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
        cyc(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1);
`ifdef STALL_STATS_EN
        check("t6 stall_cycles", bus.stall_cycles, 32'd3);
        check("t6 flush_count",  bus.flush_count,  32'd2);
`endif
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1);
        check("t6 pc top", bus.imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1);
        check("t6 pc wrap", bus.imem_addr, 32'h0);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
